sid_envelope: RTL

//  Per-voice ADSR envelope generator and VCA, directly downstream of the voice waveform stage.
//  - Decodes the voice's control, attack/decay and sustain/release registers.
//  - Produces an 8-bit envelope level.
//  - Multiplies the 12-bit unsigned (centre 'h800) waveform by it, giving a signed amplitude for the filter/mixer.

---
 rtl/sid_envelope.sv | 84 ++++++++
 1 files changed

// File: rtl/sid_envelope.sv
// sid_envelope: per-voice ADSR envelope generator with a pipelined VCA.
// Rate counter picks the step cadence; an env-dependent divider shapes decay/release exponentially.
module sid_envelope #(
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               iRstN,
  input  logic               clkEn,
  input  logic               iWE,
  input  logic [4:0]         iAddr,
  input  logic [7:0]         iData,
  input  logic [11:0]        iVoice,
  output logic [7:0]         oEnv,
  output logic signed [19:0] oOut
);
  typedef enum logic [1:0] {ATTACK, DECAY_SUSTAIN, RELEASE} envStateT;
  localparam logic [4:0] addrCtrl = 5'(BASE_ADDR + 4);
  localparam logic [4:0] addrAd   = 5'(BASE_ADDR + 5);
  localparam logic [4:0] addrSr   = 5'(BASE_ADDR + 6);
  localparam logic [14:0] rateTab [16] = '{15'd8, 15'd31, 15'd62, 15'd94, 15'd148, 15'd219,
    15'd266, 15'd312, 15'd391, 15'd976, 15'd1953, 15'd3125, 15'd3906, 15'd11719, 15'd19531, 15'd31250};
  envStateT state, stateNext;
  logic gate, gateD;
  logic [3:0] atk, dec, sus, rel, rateSel;
  logic [14:0] cnt, cntNext, rateP;
  logic [4:0] expCnt, expNext, period;
  logic [7:0] envNext, susLvl, floorLvl;
  logic rateStep, expHit;
  logic signed [19:0] voiceS, envS;
  assign rateSel  = state == ATTACK ? atk : state == DECAY_SUSTAIN ? dec : rel;
  assign rateP    = rateTab[rateSel];
  assign rateStep = clkEn && cnt == rateP;
  assign susLvl   = {sus, sus};
  assign floorLvl = state == DECAY_SUSTAIN ? susLvl : 8'd0;
  assign period   = oEnv >= 8'd94 ? 5'd1 : oEnv >= 8'd55 ? 5'd2 : oEnv >= 8'd27 ? 5'd4 :
                    oEnv >= 8'd15 ? 5'd8 : oEnv >= 8'd7 ? 5'd16 : oEnv >= 8'd1 ? 5'd30 : 5'd1;
  assign expHit   = ({1'b0, expCnt} + 6'd1) >= {1'b0, period};
  assign voiceS   = {{8{~iVoice[11]}}, ~iVoice[11], iVoice[10:0]};
  assign envS     = {12'd0, oEnv};
  // Gate edges override any rate step on the cycle they are seen.
  always_comb begin
    stateNext = state;
    envNext   = oEnv;
    expNext   = expCnt;
    cntNext   = !clkEn ? cnt : rateStep ? 15'd0 : cnt + 15'd1;
    if (gate && !gateD) begin
      stateNext = ATTACK;
      expNext   = 5'd0;
    end else if (!gate && gateD) begin
      stateNext = RELEASE;
    end else if (rateStep && state == ATTACK) begin
      envNext   = oEnv + 8'(oEnv != 8'hFF);
      stateNext = oEnv >= 8'hFE ? DECAY_SUSTAIN : ATTACK;
    end else if (rateStep) begin
      expNext = expHit ? 5'd0 : expCnt + 5'd1;
      envNext = expHit && oEnv > floorLvl ? oEnv - 8'd1 : oEnv;
    end
  end
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      state  <= RELEASE;
      gate   <= 1'b0;
      gateD  <= 1'b0;
      atk    <= 4'd0;
      dec    <= 4'd0;
      sus    <= 4'd0;
      rel    <= 4'd0;
      cnt    <= 15'd0;
      expCnt <= 5'd0;
      oEnv   <= 8'd0;
      oOut   <= 20'sd0;
    end else begin
      if (iWE && iAddr == addrCtrl) gate <= iData[0];
      if (iWE && iAddr == addrAd) {atk, dec} <= iData;
      if (iWE && iAddr == addrSr) {sus, rel} <= iData;
      gateD  <= gate;
      state  <= stateNext;
      cnt    <= cntNext;
      expCnt <= expNext;
      oEnv   <= envNext;
      oOut   <= voiceS * envS;
    end
  end
endmodule
